// File: rtl/packet_adder_mc.sv
// packet_adder_mc: round-robin multi-channel packet summer.
// Grants one channel at a time, sums a whole packet, then presents a single result beat
// carrying sum, source channel, length and overflow/truncation flags.
module packet_adder_mc #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SUM_W    = 16,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MAX_LEN  = 16,
  parameter bit          SATURATE = 1'b0,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum,
  output logic [CH_W-1:0]          out_ch,
  output logic [LEN_W-1:0]         out_len,
  output logic                     out_ovf,
  output logic                     out_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StOut} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [CH_W-1:0]   pick;
  logic              found;
  logic [DATA_W-1:0] word;
  logic [SUM_W:0]    raw;
  logic [LEN_W-1:0]  len_inc;

  // Round-robin search starting just after the previously served channel.
  always_comb begin
    pick  = last_grant_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      logic [CH_W-1:0] cand;
      cand = CH_W'((32'(last_grant_q) + i) % NUM_CH);
      if (!found && in_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    word = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_q == CH_W'(c)) word = in_data[c*DATA_W +: DATA_W];
    end
  end

  // Next-state logic for the arbitration/accumulation FSM.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    acc_d        = acc_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    err_d        = err_q;
    raw          = {1'b0, acc_q} + {{(SUM_W + 1 - DATA_W){1'b0}}, word};
    len_inc      = len_q + LEN_W'(1);

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          acc_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (in_valid[grant_q]) begin
          if (raw[SUM_W]) begin
            ovf_d = 1'b1;
            // A clamped sum stays at all-ones: any further nonzero word overflows again.
            acc_d = SATURATE ? {SUM_W{1'b1}} : raw[SUM_W-1:0];
          end else begin
            acc_d = raw[SUM_W-1:0];
          end
          len_d = len_inc;
          if (in_last[grant_q]) begin
            state_d = StOut;
          end else if (len_inc == LEN_W'(MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = StOut;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; last_grant resets so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      acc_q        <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      acc_q        <= acc_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  // Outputs come straight from registered state; no input-to-output paths.
  always_comb begin
    in_ready = '0;
    if (state_q == StAccum) in_ready[grant_q] = 1'b1;
    out_valid = (state_q == StOut);
    out_sum   = acc_q;
    out_ch    = grant_q;
    out_len   = len_q;
    out_ovf   = ovf_q;
    out_err   = err_q;
  end

endmodule

// File: tb/tb_packet_adder_mc.sv
// Scoreboard bench: two instances (wrap and saturate, 8-bit sum, MAX_LEN=4) share stimulus;
// expected results are queued per instance and checked by independent monitors.
module tb_packet_adder_mc;

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned ML = 4;

  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] ch;
    logic [2:0] len;
    logic       ovf;
    logic       err;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [NC-1:0]   in_valid;
  logic [NC*DW-1:0] in_data;
  logic [NC-1:0]   in_last;
  logic            out_ready;

  logic [NC-1:0]   in_ready_w, in_ready_s;
  logic            out_valid_w, out_valid_s;
  logic [SW-1:0]   out_sum_w, out_sum_s;
  logic [1:0]      out_ch_w, out_ch_s;
  logic [2:0]      out_len_w, out_len_s;
  logic            out_ovf_w, out_ovf_s, out_err_w, out_err_s;

  exp_t q_w[$];
  exp_t q_s[$];
  exp_t ew, es;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_pop_w = 0;
  int   n_pop_s = 0;

  packet_adder_mc #(
    .DATA_W(DW), .SUM_W(SW), .NUM_CH(NC), .MAX_LEN(ML), .SATURATE(1'b0)
  ) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
    .out_ch(out_ch_w), .out_len(out_len_w), .out_ovf(out_ovf_w), .out_err(out_err_w)
  );

  packet_adder_mc #(
    .DATA_W(DW), .SUM_W(SW), .NUM_CH(NC), .MAX_LEN(ML), .SATURATE(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s),
    .out_ch(out_ch_s), .out_len(out_len_s), .out_ovf(out_ovf_s), .out_err(out_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] sw, input logic [7:0] ss, input logic [1:0] ch,
                      input logic [2:0] len, input logic ovf, input logic err);
    q_w.push_back('{sum: sw, ch: ch, len: len, ovf: ovf, err: err});
    q_s.push_back('{sum: ss, ch: ch, len: len, ovf: ovf, err: err});
  endtask

  // Monitor for the wrapping instance.
  always @(negedge clk) begin
    if (!rst && out_valid_w && out_ready) begin
      if (q_w.size() == 0) begin
        chk("w_unexpected_result", 1, 0);
      end else begin
        ew = q_w.pop_front();
        n_pop_w++;
        chk("w_sum", out_sum_w, ew.sum);
        chk("w_ch",  out_ch_w,  ew.ch);
        chk("w_len", out_len_w, ew.len);
        chk("w_ovf", out_ovf_w, ew.ovf);
        chk("w_err", out_err_w, ew.err);
      end
    end
  end

  // Monitor for the saturating instance.
  always @(negedge clk) begin
    if (!rst && out_valid_s && out_ready) begin
      if (q_s.size() == 0) begin
        chk("s_unexpected_result", 1, 0);
      end else begin
        es = q_s.pop_front();
        n_pop_s++;
        chk("s_sum", out_sum_s, es.sum);
        chk("s_ch",  out_ch_s,  es.ch);
        chk("s_len", out_len_s, es.len);
        chk("s_ovf", out_ovf_s, es.ovf);
        chk("s_err", out_err_s, es.err);
      end
    end
  end

  task automatic wait_ready(input int ch);
    int n = 0;
    @(negedge clk);
    while (!in_ready_w[ch] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
  endtask

  // Present one word, hold it until accepted, return 1 time unit after the beat edge.
  task automatic send_word(input int ch, input logic [7:0] d, input logic l);
    in_valid[ch]         = 1'b1;
    in_data[ch*DW +: DW] = d;
    in_last[ch]          = l;
    wait_ready(ch);
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int ch);
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((q_w.size() != 0 || q_s.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", (n < 200), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready_w"},  in_ready_w,  0);
    chk({tag, "_in_ready_s"},  in_ready_s,  0);
    chk({tag, "_out_valid_w"}, out_valid_w, 0);
    chk({tag, "_out_valid_s"}, out_valid_s, 0);
    chk({tag, "_out_sum_w"},   out_sum_w,   0);
    chk({tag, "_out_ch_w"},    out_ch_w,    0);
    chk({tag, "_out_len_w"},   out_len_w,   0);
    chk({tag, "_out_ovf_w"},   out_ovf_w,   0);
    chk({tag, "_out_err_w"},   out_err_w,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int n;
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Round-robin: all channels continuously offer 1-word packets.
    push(8'd10, 8'd10, 2'd0, 3'd1, 1'b0, 1'b0);
    push(8'd20, 8'd20, 2'd1, 3'd1, 1'b0, 1'b0);
    push(8'd30, 8'd30, 2'd2, 3'd1, 1'b0, 1'b0);
    push(8'd40, 8'd40, 2'd3, 3'd1, 1'b0, 1'b0);
    push(8'd10, 8'd10, 2'd0, 3'd1, 1'b0, 1'b0);
    in_data  = {8'd40, 8'd30, 8'd20, 8'd10};
    in_last  = 4'hF;
    in_valid = 4'hF;
    hs = 0;
    n  = 0;
    while (hs < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (out_valid_w && out_ready) hs++;
    end
    chk("rr_handshakes", hs, 5);
    @(posedge clk);
    #1;
    in_valid = '0;
    in_last  = '0;
    wait_drain();

    // Single packet 3,5,7 on ch0; result must appear the cycle after the last beat.
    push(8'd15, 8'd15, 2'd0, 3'd3, 1'b0, 1'b0);
    send_word(0, 8'd3, 1'b0);
    send_word(0, 8'd5, 1'b0);
    send_word(0, 8'd7, 1'b1);
    drop(0);
    @(negedge clk);
    chk("single_out_valid_next_cycle", out_valid_w, 1);
    chk("single_in_ready_low_in_out", in_ready_w, 0);
    wait_drain();

    // Overflow 200+100+10: wrap gives 54, saturate clamps to 255.
    push(8'd54, 8'd255, 2'd0, 3'd3, 1'b1, 1'b0);
    send_word(0, 8'd200, 1'b0);
    send_word(0, 8'd100, 1'b0);
    send_word(0, 8'd10, 1'b1);
    drop(0);
    wait_drain();

    // Truncation at MAX_LEN=4: six ones on ch1 split into 4 (err) and 2.
    push(8'd4, 8'd4, 2'd1, 3'd4, 1'b0, 1'b1);
    push(8'd2, 8'd2, 2'd1, 3'd2, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_word(1, 8'd1, (i == 5));
    drop(1);
    wait_drain();

    // Backpressure: ch2 result held while ch3 waits.
    push(8'd7, 8'd7, 2'd2, 3'd1, 1'b0, 1'b0);
    push(8'd9, 8'd9, 2'd3, 3'd1, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_data[3*DW +: DW] = 8'd9;
    in_last[3]  = 1'b1;
    in_valid[3] = 1'b1;
    send_word(2, 8'd7, 1'b1);
    drop(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid_w, 1);
      chk("bp_out_sum",   out_sum_w,   7);
      chk("bp_out_ch",    out_ch_w,    2);
      chk("bp_in_ready",  in_ready_w,  0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_ready(3);
    @(posedge clk);
    #1;
    drop(3);
    wait_drain();

    // Stall: 3-cycle gap mid-packet on ch1 must not disturb the sum.
    push(8'd6, 8'd6, 2'd1, 3'd3, 1'b0, 1'b0);
    send_word(1, 8'd1, 1'b0);
    drop(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_no_out_valid", out_valid_w, 0);
    end
    @(posedge clk);
    #1;
    send_word(1, 8'd2, 1'b0);
    send_word(1, 8'd3, 1'b1);
    drop(1);
    wait_drain();

    // Reset mid-packet: ch2 packet aborted, then ch0 beats ch3 thanks to reset priority.
    send_word(2, 8'd5, 1'b0);
    send_word(2, 8'd5, 1'b0);
    drop(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    push(8'd10, 8'd10, 2'd0, 3'd2, 1'b0, 1'b0);
    push(8'd50, 8'd50, 2'd3, 3'd1, 1'b0, 1'b0);
    in_data[3*DW +: DW] = 8'd50;
    in_last[3]  = 1'b1;
    in_valid[3] = 1'b1;
    send_word(0, 8'd9, 1'b0);
    send_word(0, 8'd1, 1'b1);
    drop(0);
    wait_ready(3);
    @(posedge clk);
    #1;
    drop(3);
    wait_drain();

    repeat (3) @(posedge clk);
    chk("results_w", n_pop_w, 14);
    chk("results_s", n_pop_s, 14);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
